// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter slice.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } imem_owner_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int unsigned IMEM_DEPTH = 4096;

endpackage

// File: rtl/imem_arbiter_streak_arbiter.sv
// Two-requester arbiter: data wins contention until fetch has been passed over
// MAX_STREAK times in a row, then fetch gets one grant.
module streak_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  output logic f_gnt,
  output logic d_gnt
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    streak_d = '0;
    if (!rst) begin
      if (f_req && d_req) begin
        if (streak_q < STREAK_MAX) begin
          d_gnt    = 1'b1;
          streak_d = streak_q + SW'(1);
        end else begin
          f_gnt = 1'b1;
        end
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction ROM between fetch and the data-side reader;
// one grant per cycle, response routed back to its owner one cycle later.
module imem_arbiter #(
  parameter int unsigned DEPTH      = imem_arbiter_pkg::IMEM_DEPTH,
  parameter int unsigned MAX_STREAK = 3,
  parameter logic [31:0] NOP_INSN   = imem_arbiter_pkg::NOP_INSN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  input  logic                     f_kill,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [31:0]              f_rdata,
  input  logic                     d_req,
  input  logic [31:0]              d_addr,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic                     d_err,
  output logic                     m_en,
  output logic [$clog2(DEPTH)-1:0] m_addr,
  input  logic [31:0]              m_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  imem_arbiter_pkg::imem_owner_e owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] sel_addr;
  logic        range_err;
  logic        misalign;

  streak_arbiter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .f_req(f_req),
    .d_req(d_req),
    .f_gnt(f_gnt),
    .d_gnt(d_gnt)
  );

  always_comb begin
    sel_addr  = d_gnt ? d_addr : f_addr;
    range_err = {2'b00, sel_addr[31:2]} >= DEPTH;
    misalign  = d_gnt && (sel_addr[1:0] != 2'b00);
    err_d     = range_err || misalign;
    m_en      = (f_gnt || d_gnt) && !err_d;
    m_addr    = sel_addr[AW+1:2];
    owner_d   = imem_arbiter_pkg::OWN_NONE;
    if (d_gnt)      owner_d = imem_arbiter_pkg::OWN_DATA;
    else if (f_gnt) owner_d = imem_arbiter_pkg::OWN_FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= imem_arbiter_pkg::OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Kill only masks the fetch response landing this cycle; the grant path is untouched.
  always_comb begin
    f_rvalid = (owner_q == imem_arbiter_pkg::OWN_FETCH) && !f_kill;
    f_rdata  = (f_rvalid && !err_q) ? m_rdata : NOP_INSN;
    d_rvalid = (owner_q == imem_arbiter_pkg::OWN_DATA);
    d_err    = d_rvalid && err_q;
    d_rdata  = (d_rvalid && !err_q) ? m_rdata : '0;
  end

endmodule
